// File: rtl/profile_counter_pkg.sv
// rtl/profile_counter_pkg.sv - shared constants and select-width helper for the profile counter bank
package profile_counter_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_NUM_CH = 4;

  // Select ports need at least one bit even for a single-channel bank.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/profile_counter_channel.sv
// rtl/profile_counter_channel.sv - one up/down counter with sticky boundary flag and shadow register
module profile_counter_channel
  import profile_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_direction,
  input  logic             i_clear,
  input  logic             i_saturate,
  input  logic             i_freeze,
  input  logic             i_snap,
  output logic [WIDTH-1:0] o_shadow,
  output logic             o_overflow
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_shadow;
  logic             r_overflow;

  logic [WIDTH-1:0] w_count_step;
  logic             w_at_bound;

  assign w_count_step = i_direction ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
  assign w_at_bound   = i_direction ? (r_count == {WIDTH{1'b1}}) : (r_count == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count    <= '0;
      r_shadow   <= '0;
      r_overflow <= 1'b0;
    end else begin
      // Shadow captures the pre-edge count, independent of clear/count this edge.
      if (i_snap) begin
        r_shadow <= r_count;
      end
      if (i_clear) begin
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else if (!i_freeze && i_enable) begin
        if (w_at_bound) begin
          r_overflow <= 1'b1;
          if (!i_saturate) begin
            r_count <= w_count_step;
          end
        end else begin
          r_count <= w_count_step;
        end
      end
    end
  end

  assign o_shadow   = r_shadow;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/profile_counter_bank.sv
// rtl/profile_counter_bank.sv - bank of profiling counters with snapshot shadows and registered read port
module profile_counter_bank
  import profile_counter_pkg::*;
#(
  parameter  int NUM_CH = DEFAULT_NUM_CH,
  parameter  int WIDTH  = DEFAULT_WIDTH,
  localparam int SEL_W  = sel_width(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] enable,
  input  logic [NUM_CH-1:0] direction,
  input  logic [NUM_CH-1:0] clear,
  input  logic              saturate,
  input  logic              freeze,
  input  logic              snapStrobe,
  input  logic              readReq,
  input  logic [SEL_W-1:0]  readSel,
  output logic              readValid,
  output logic [WIDTH-1:0]  readValue,
  output logic [NUM_CH-1:0] overflow
);

  logic [WIDTH-1:0] w_shadow [NUM_CH];
  logic [WIDTH-1:0] w_sel_value;

  logic             r_read_valid;
  logic [WIDTH-1:0] r_read_value;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    profile_counter_channel #(
      .WIDTH(WIDTH)
    ) u_channel (
      .clock      (clock),
      .reset      (reset),
      .i_enable   (enable[g]),
      .i_direction(direction[g]),
      .i_clear    (clear[g]),
      .i_saturate (saturate),
      .i_freeze   (freeze),
      .i_snap     (snapStrobe),
      .o_shadow   (w_shadow[g]),
      .o_overflow (overflow[g])
    );
  end

  // Out-of-range selects match no channel and read as zero.
  always_comb begin
    w_sel_value = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (readSel == SEL_W'(i)) begin
        w_sel_value = w_shadow[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_read_valid <= 1'b0;
      r_read_value <= '0;
    end else begin
      r_read_valid <= readReq;
      r_read_value <= readReq ? w_sel_value : '0;
    end
  end

  assign readValid = r_read_valid;
  assign readValue = r_read_value;

endmodule

// File: tb/tb_profile_counter_bank.sv
// tb/tb_profile_counter_bank.sv - self-checking bench for profile_counter_bank against a behavioural model
module tb_profile_counter_bank;

  localparam int W   = 8;
  localparam int NCH = 4;
  localparam int MAXV = (1 << W) - 1;

  logic           clock = 1'b0;
  logic           reset;
  logic [NCH-1:0] enable, direction, clear;
  logic           saturate, freeze, snapStrobe, readReq;
  logic [1:0]     readSel;
  logic           readValid, readValid3;
  logic [W-1:0]   readValue, readValue3;
  logic [NCH-1:0] overflow;
  logic [2:0]     overflow3;

  int n_checks = 0;
  int n_errors = 0;

  int m_cnt [NCH];
  int m_sh  [NCH];
  bit m_ovf [NCH];
  bit m_valid;
  int m_val, m_val3;

  always #5 clock = ~clock;

  profile_counter_bank #(.NUM_CH(NCH), .WIDTH(W)) dut (
    .clock(clock), .reset(reset), .enable(enable), .direction(direction),
    .clear(clear), .saturate(saturate), .freeze(freeze), .snapStrobe(snapStrobe),
    .readReq(readReq), .readSel(readSel), .readValid(readValid),
    .readValue(readValue), .overflow(overflow)
  );

  // Three-channel instance: readSel==3 is out of range here.
  profile_counter_bank #(.NUM_CH(3), .WIDTH(W)) dut3 (
    .clock(clock), .reset(reset), .enable(enable[2:0]), .direction(direction[2:0]),
    .clear(clear[2:0]), .saturate(saturate), .freeze(freeze), .snapStrobe(snapStrobe),
    .readReq(readReq), .readSel(readSel), .readValid(readValid3),
    .readValue(readValue3), .overflow(overflow3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NCH-1:0] ovf_vec();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  task automatic tick();
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = 0; m_sh[i] = 0; m_ovf[i] = 0;
      end
      m_valid = 0; m_val = 0; m_val3 = 0;
    end else begin
      m_valid = readReq;
      m_val   = (readReq && readSel < NCH) ? m_sh[readSel] : 0;
      m_val3  = (readReq && readSel < 3)   ? m_sh[readSel] : 0;
      if (snapStrobe)
        for (int i = 0; i < NCH; i++) m_sh[i] = m_cnt[i];
      for (int i = 0; i < NCH; i++) begin
        if (clear[i]) begin
          m_cnt[i] = 0; m_ovf[i] = 0;
        end else if (!freeze && enable[i]) begin
          if (direction[i]) begin
            if (m_cnt[i] == MAXV) begin
              m_ovf[i] = 1; m_cnt[i] = saturate ? MAXV : 0;
            end else m_cnt[i]++;
          end else begin
            if (m_cnt[i] == 0) begin
              m_ovf[i] = 1; m_cnt[i] = saturate ? 0 : MAXV;
            end else m_cnt[i]--;
          end
        end
      end
    end
    @(posedge clock);
    #1;
    check("valid", readValid, m_valid);
    check("value", readValue, m_val);
    check("ovf", overflow, ovf_vec());
    check("valid3", readValid3, m_valid);
    check("value3", readValue3, m_val3);
    check("ovf3", overflow3, ovf_vec() & 4'b0111);
  endtask

  task automatic set_in(input logic [NCH-1:0] en, input logic [NCH-1:0] dir,
                        input logic [NCH-1:0] clr, input logic sat, input logic frz,
                        input logic snap, input logic rreq, input logic [1:0] sel);
    enable = en; direction = dir; clear = clr; saturate = sat; freeze = frz;
    snapStrobe = snap; readReq = rreq; readSel = sel;
  endtask

  task automatic idle();
    set_in('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    for (int i = 0; i < NCH; i++) begin m_cnt[i] = 0; m_sh[i] = 0; m_ovf[i] = 0; end
    tick(); tick();
    check("reset_ovf", overflow, 4'b0000);
    check("reset_valid", readValid, 1'b0);

    reset = 1'b1;
    set_in(4'b0001, 4'b1111, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (10) tick();
    check("ch0_ovf_after10", overflow, 4'b0000);

    set_in('0, '0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    tick();
    check("snap_same_edge_old", readValue, 8'd0);
    check("snap_same_edge_valid", readValid, 1'b1);
    set_in('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    tick();
    check("ch0_is_10", readValue, 8'd10);
    set_in('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    tick();
    check("ch1_is_0", readValue, 8'd0);

    set_in(4'b0010, 4'b0010, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (255) tick();
    check("ch1_at_max_no_ovf", overflow[1], 1'b0);
    tick();
    check("ch1_wrap_ovf", overflow[1], 1'b1);
    set_in(4'b0010, 4'b0000, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    set_in('0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    set_in('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    tick();
    check("ch1_wrapped_down_255", readValue, 8'd255);
    set_in(4'b0010, 4'b0010, '0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    set_in('0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    set_in('0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
    tick();
    check("ch1_sat_hold_255", readValue, 8'd255);
    check("ch1_sat_ovf", overflow[1], 1'b1);

    set_in(4'b0100, 4'b0000, '0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    check("ch2_sat_low_ovf", overflow[2], 1'b1);
    set_in(4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    check("ch2_clear_ovf", overflow[2], 1'b0);

    set_in(4'b1111, 4'b1010, '0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    repeat (5) tick();
    set_in('0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3);
    tick();
    for (int s = 0; s < NCH; s++) begin
      set_in('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 2'(s));
      tick();
    end
    check("oor_valid3", readValid3, 1'b1);
    check("oor_value3", readValue3, 8'd0);

    set_in(4'b1111, 4'b1111, '0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    reset = 1'b0;
    tick();
    check("midreset_valid", readValid, 1'b0);
    check("midreset_ovf", overflow, 4'b0000);
    reset = 1'b1;
    set_in('0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    set_in('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    tick();
    check("midreset_ch1_0", readValue, 8'd0);

    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(0, 59) != 0);
      enable     = 4'($urandom);
      direction  = ($urandom_range(0, 2) == 0) ? 4'b1111 : 4'($urandom);
      clear      = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
      saturate   = 1'($urandom);
      freeze     = ($urandom_range(0, 7) == 0);
      snapStrobe = ($urandom_range(0, 3) == 0);
      readReq    = 1'($urandom);
      readSel    = 2'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
